// File: rtl/sop_engine_pkg.sv
// Shared constants and config-row layout for the shared-product SOP evaluator.
package sop_engine_pkg;
  localparam int unsigned N_IN   = 4;
  localparam int unsigned N_OUT  = 2;
  localparam int unsigned N_PROD = 3;
  localparam int unsigned LIT_W  = 2 * N_IN;
  localparam int unsigned CFG_W  = LIT_W + N_OUT;
  localparam int unsigned ADDR_W = $clog2(N_PROD + 1);

  localparam logic [1:0] LIT_ABSENT = 2'b00;
  localparam logic [1:0] LIT_POS    = 2'b01;
  localparam logic [1:0] LIT_NEG    = 2'b10;
  localparam logic [1:0] LIT_ZERO   = 2'b11;

  typedef struct packed {
    logic [N_OUT-1:0] act;
    logic [LIT_W-1:0] lit;
  } row_t;
endpackage

// File: rtl/sop_product_term.sv
// One combinational product term: AND of the literals selected by a 2-bit code per input.
module sop_product_term
  import sop_engine_pkg::*;
(
  input  logic [LIT_W-1:0] i_lit,
  input  logic [N_IN-1:0]  i_vec,
  output logic             o_prod_c
);

  logic [N_IN-1:0] w_kill;

  // An absent literal never kills the product; ZERO always does.
  for (genvar i = 0; i < N_IN; i++) begin : g_lit
    logic [1:0] w_code;
    assign w_code    = i_lit[2*i +: 2];
    assign w_kill[i] = (w_code != LIT_ABSENT) &
                       ((w_code == LIT_ZERO) |
                        ((w_code == LIT_POS) & ~i_vec[i]) |
                        ((w_code == LIT_NEG) &  i_vec[i]));
  end

  assign o_prod_c = ~|w_kill;

endmodule

// File: rtl/sop_shared_engine.sv
// Programmable two-stage shared-product SOP evaluator with shadow/active config,
// drain-before-commit control and on-the-fly error statistics.
module sop_shared_engine
  import sop_engine_pkg::*;
#(
  parameter int unsigned ET    = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CFG_W-1:0]  cfg_data,
  input  logic              cfg_commit,
  output logic              cfg_pending,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_vec,
  input  logic [N_OUT-1:0]  in_exact,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_vec,
  output logic              out_err,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [N_OUT-1:0]  max_err
);

  logic                           r_pend;
  logic                           r_s1_v, r_s2_v;
  logic [N_PROD-1:0]              r_s1_prod;
  logic [N_OUT-1:0]               r_s1_exact;
  logic [N_OUT-1:0]               r_out_vec, r_diff;
  logic                           r_out_err;
  logic [CNT_W-1:0]               r_err_cnt;
  logic [N_OUT-1:0]               r_max_err;
  logic [N_OUT-1:0]               r_shd_en, r_act_en;

  logic [N_OUT-1:0]               w_en_nxt;
  logic [N_PROD-1:0]              w_prod;
  logic [N_OUT-1:0][N_PROD-1:0]   w_col;
  logic [N_OUT-1:0]               w_vec, w_diff;
  logic                           w_err;
  logic                           w_s2_load, w_s1_adv, w_in_fire, w_out_fire;
  logic                           w_empty, w_copy;

  // Handshake and commit control.
  assign w_s2_load  = ~r_s2_v | out_ready;
  assign w_s1_adv   = r_s1_v & w_s2_load;
  assign in_ready   = ~r_pend & (~r_s1_v | w_s1_adv);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_s2_v & out_ready;
  assign w_empty    = ~r_s1_v & ~r_s2_v;
  assign w_copy     = w_empty & (r_pend | (cfg_commit & ~w_in_fire));

  // Per-row shadow/active config and the product term built from the active row.
  for (genvar p = 0; p < N_PROD; p++) begin : g_row
    row_t r_shd, r_act;
    row_t w_nxt;
    assign w_nxt = (cfg_we && cfg_addr == ADDR_W'(p)) ? row_t'(cfg_data) : r_shd;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_shd <= '0;
        r_act <= '0;
      end else begin
        r_shd <= w_nxt;
        if (w_copy) r_act <= w_nxt;
      end
    end

    sop_product_term u_term (
      .i_lit    (r_act.lit),
      .i_vec    (in_vec),
      .o_prod_c (w_prod[p])
    );

    for (genvar j = 0; j < N_OUT; j++) begin : g_act
      assign w_col[j][p] = r_act.act[j];
    end
  end

  assign w_en_nxt = (cfg_we && cfg_addr == ADDR_W'(N_PROD)) ? cfg_data[N_OUT-1:0] : r_shd_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shd_en <= '0;
      r_act_en <= '0;
    end else begin
      r_shd_en <= w_en_nxt;
      if (w_copy) r_act_en <= w_en_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_pend <= 1'b0;
    else        r_pend <= ~w_copy & (r_pend | cfg_commit);
  end

  // Stage 2 combinational: OR of activated products, then |approx - exact|.
  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    assign w_vec[j] = r_act_en[j] & |(r_s1_prod & w_col[j]);
  end
  assign w_diff = (w_vec >= r_s1_exact) ? (w_vec - r_s1_exact) : (r_s1_exact - w_vec);
  assign w_err  = 32'(w_diff) > ET;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v     <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_exact <= '0;
    end else if (~r_s1_v | w_s1_adv) begin
      r_s1_v <= w_in_fire;
      if (w_in_fire) begin
        r_s1_prod  <= w_prod;
        r_s1_exact <= in_exact;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_v    <= 1'b0;
      r_out_vec <= '0;
      r_diff    <= '0;
      r_out_err <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_out_vec <= w_vec;
        r_diff    <= w_diff;
        r_out_err <= w_err;
      end
    end
  end

  // Statistics update on each output handshake; clear has priority.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_stats) begin
      r_err_cnt <= '0;
      r_max_err <= '0;
    end else if (w_out_fire) begin
      if (r_out_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
      if (r_diff > r_max_err)           r_max_err <= r_diff;
    end
  end

  assign cfg_pending = r_pend;
  assign out_valid   = r_s2_v;
  assign out_vec     = r_out_vec;
  assign out_err     = r_out_err;
  assign err_cnt     = r_err_cnt;
  assign max_err     = r_max_err;

endmodule

// File: tb/tb_sop_shared_engine.sv
// Randomized self-checking bench for sop_shared_engine against a rule-level reference model.
module tb_sop_shared_engine;

  logic        clk;
  logic        rst_n, cfg_we, cfg_commit, in_valid, out_ready, clr_stats;
  logic [1:0]  cfg_addr;
  logic [9:0]  cfg_data;
  logic [3:0]  in_vec;
  logic [1:0]  in_exact;
  logic        cfg_pending, in_ready, out_valid, out_err;
  logic [1:0]  out_vec, max_err;
  logic [15:0] err_cnt;
  logic        s_cfg_pending, s_in_ready, s_out_valid, s_out_err;
  logic [1:0]  s_out_vec, s_max_err, s_err_cnt;

  sop_shared_engine dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .in_exact(in_exact), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_err(out_err), .clr_stats(clr_stats), .err_cnt(err_cnt), .max_err(max_err)
  );

  // Second instance with a 2-bit error counter for saturation.
  sop_shared_engine #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(s_cfg_pending), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_vec(in_vec), .in_exact(in_exact), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_vec(s_out_vec), .out_err(s_out_err), .clr_stats(clr_stats), .err_cnt(s_err_cnt), .max_err(s_max_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0] vec;
    logic [1:0] diff;
    logic       err;
  } exp_t;

  logic [7:0] m_shd_lit [3];
  logic [1:0] m_shd_act [3];
  logic [7:0] m_act_lit [3];
  logic [1:0] m_act_act [3];
  logic [1:0] m_shd_en, m_act_en;
  exp_t       q [$];
  int         m_cnt, m_cnt_s, m_max;
  int         checks, failures, n_out;
  bit         mon_en, bp_en;
  int         bp_i;
  logic [3:0] bp_pat;

  function automatic logic [1:0] m_eval(input logic [3:0] v);
    logic [1:0] r;
    bit         prod;
    int         code;
    r = 2'b00;
    for (int p = 0; p < 3; p++) begin
      prod = 1'b1;
      for (int i = 0; i < 4; i++) begin
        code = int'((m_act_lit[p] >> (2 * i)) & 8'd3);
        if (code == 3 || (code == 1 && !v[i]) || (code == 2 && v[i])) prod = 1'b0;
      end
      if (prod) r = r | m_act_act[p];
    end
    return r & m_act_en;
  endfunction

  function automatic exp_t m_exp(input logic [3:0] v, input logic [1:0] ex);
    exp_t e;
    int   a, b, d;
    e.vec  = m_eval(v);
    a      = int'(e.vec);
    b      = int'(ex);
    d      = (a > b) ? a - b : b - a;
    e.diff = 2'(d);
    e.err  = (d > 2);
    return e;
  endfunction

  function automatic void model_copy();
    for (int p = 0; p < 3; p++) begin
      m_act_lit[p] = m_shd_lit[p];
      m_act_act[p] = m_shd_act[p];
    end
    m_act_en = m_shd_en;
  endfunction

  function automatic void model_cfg_clear();
    for (int p = 0; p < 3; p++) begin
      m_shd_lit[p] = 8'h00;
      m_shd_act[p] = 2'b00;
    end
    m_shd_en = 2'b00;
    model_copy();
  endfunction

  // Scoreboard: output order/value/stability and running statistics.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (err_cnt !== 16'(m_cnt) || max_err !== 2'(m_max) || s_err_cnt !== 2'(m_cnt_s) ||
          s_max_err !== 2'(m_max)) begin
        failures++;
        $display("FAIL stats: err_cnt=%0d max_err=%0d sat_cnt=%0d, required %0d %0d %0d",
                 err_cnt, max_err, s_err_cnt, m_cnt, m_max, m_cnt_s);
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL out_extra: out_vec=%b with nothing in flight", out_vec);
        end else if (out_vec !== q[0].vec || out_err !== q[0].err || s_out_valid !== 1'b1 ||
                     s_out_vec !== q[0].vec || s_out_err !== q[0].err) begin
          failures++;
          $display("FAIL out_data: vec=%b err=%b (sat vec=%b), required vec=%b err=%b",
                   out_vec, out_err, s_out_vec, q[0].vec, q[0].err);
        end
      end
      if (!rst_n) begin
        q.delete();
        m_cnt = 0; m_cnt_s = 0; m_max = 0;
      end else begin
        if (clr_stats) begin
          m_cnt = 0; m_cnt_s = 0; m_max = 0;
        end else if (out_valid && out_ready && q.size() > 0) begin
          if (q[0].err) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
          end
          if (int'(q[0].diff) > m_max) m_max = int'(q[0].diff);
        end
        if (out_valid && out_ready && q.size() > 0) begin
          void'(q.pop_front());
          n_out++;
        end
        if (in_valid && in_ready) q.push_back(m_exp(in_vec, in_exact));
      end
    end
  end

  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      out_ready = bp_pat[bp_i % 4];
      bp_i++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [9:0] data, input bit commit);
    cfg_we = 1'b1; cfg_addr = 2'(addr); cfg_data = data; cfg_commit = commit;
    if (addr < 3) begin
      m_shd_lit[addr] = data[7:0];
      m_shd_act[addr] = data[9:8];
    end else if (addr == 3) begin
      m_shd_en = data[1:0];
    end
    if (commit) model_copy();
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    model_copy();
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic send(input logic [3:0] v, input logic [1:0] ex);
    bit acc;
    acc = 1'b0;
    in_vec = v; in_exact = ex; in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%b after 50 cycles, required 1", in_ready);
    end
  endtask

  task automatic send_expect(input logic [3:0] v, input logic [1:0] ex, input logic [1:0] want,
                             output int lat);
    bit found;
    found = 1'b0;
    lat = -1;
    send(v, ex);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        lat = k;
      end
    end
    checks++;
    if (!found || out_vec !== want) begin
      failures++;
      $display("FAIL result in=%b: out_valid=%b out_vec=%b, required out_vec=%b", v, found, out_vec, want);
    end
    tick();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = (q.size() == 0) && !out_valid;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain: %0d results outstanding, required 0", q.size());
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({out_valid, out_vec, out_err, cfg_pending, in_ready} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_ctrl: valid=%b vec=%b err=%b pend=%b ready=%b, required 0 00 0 0 1",
               out_valid, out_vec, out_err, cfg_pending, in_ready);
    end
    checks++;
    if (err_cnt !== 16'd0 || max_err !== 2'd0 || s_err_cnt !== 2'd0 ||
        s_in_ready !== 1'b1 || s_cfg_pending !== 1'b0) begin
      failures++;
      $display("FAIL reset_stats: err_cnt=%0d max_err=%0d sat_cnt=%0d, required 0 0 0",
               err_cnt, max_err, s_err_cnt);
    end
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_const();
    int lat;
    cfg_write(0, {2'b01, 8'h10}, 1'b0);
    cfg_write(1, {2'b01, 8'h01}, 1'b0);
    cfg_write(2, {2'b01, 8'h00}, 1'b0);
    cfg_write(3, 10'h001, 1'b1);
    out_ready = 1'b1;
    send_expect(4'b0000, 2'd0, 2'b01, lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL latency: out_valid after %0d extra cycles, required 1", lat);
    end
    for (int i = 0; i < 6; i++) send_expect(4'($urandom), 2'($urandom), 2'b01, lat);
    cfg_write(3, 10'h000, 1'b1);
    send_expect(4'($urandom), 2'd0, 2'b00, lat);
  endtask

  task automatic test_literal();
    int lat;
    cfg_write(0, {2'b10, 8'h48}, 1'b0);        // ~in1 & in3
    cfg_write(1, {2'b00, 8'($urandom)}, 1'b0);
    cfg_write(2, {2'b00, 8'($urandom)}, 1'b0);
    cfg_write(3, 10'h003, 1'b1);
    send_expect(4'b1000, 2'd0, 2'b10, lat);
    send_expect(4'b1010, 2'd0, 2'b00, lat);
    cfg_write(0, {2'b10, 8'h4B}, 1'b1);
    for (int i = 0; i < 4; i++) send_expect(4'($urandom), 2'd0, 2'b00, lat);
    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < 4; p++) cfg_write(p, 10'($urandom), 1'b0);
      commit();
      for (int i = 0; i < 6; i++) send(4'($urandom), 2'($urandom));
      drain();
    end
  endtask

  task automatic test_stats();
    int lat;
    cfg_write(0, {2'b11, 8'h00}, 1'b0);
    cfg_write(1, 10'h000, 1'b0);
    cfg_write(2, 10'h000, 1'b0);
    cfg_write(3, 10'h003, 1'b1);
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    send_expect(4'($urandom), 2'd0, 2'b11, lat);
    checks++;
    if (err_cnt !== 16'd1 || max_err !== 2'd3) begin
      failures++;
      $display("FAIL err_first: err_cnt=%0d max_err=%0d, required 1 3", err_cnt, max_err);
    end
    send_expect(4'($urandom), 2'd2, 2'b11, lat);
    checks++;
    if (err_cnt !== 16'd1 || max_err !== 2'd3) begin
      failures++;
      $display("FAIL err_below_et: err_cnt=%0d max_err=%0d, required 1 3", err_cnt, max_err);
    end
    for (int i = 0; i < 5; i++) send_expect(4'($urandom), 2'd0, 2'b11, lat);
    checks++;
    if (err_cnt !== 16'd6 || s_err_cnt !== 2'd3) begin
      failures++;
      $display("FAIL saturate: err_cnt=%0d sat_cnt=%0d, required 6 3", err_cnt, s_err_cnt);
    end
    out_ready = 1'b0;
    send(4'($urandom), 2'd0);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
    tick();
    out_ready = 1'b1; clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    checks++;
    if (err_cnt !== 16'd0 || max_err !== 2'd0 || s_err_cnt !== 2'd0) begin
      failures++;
      $display("FAIL clr_vs_count: err_cnt=%0d max_err=%0d sat_cnt=%0d, required 0 0 0",
               err_cnt, max_err, s_err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    for (int p = 0; p < 4; p++) cfg_write(p, 10'($urandom), 1'b0);
    commit();
    n0 = n_out;
    bp_pat = 4'b1001;
    bp_i = 0;
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++) send(4'($urandom), 2'($urandom));
    in_valid = 1'b0;
    bp_en = 1'b0;
    drain();
    checks++;
    if (n_out - n0 !== 8) begin
      failures++;
      $display("FAIL stream_count: %0d results delivered, required 8", n_out - n0);
    end
  endtask

  task automatic test_commit();
    int lat;
    cfg_write(0, {2'b01, 8'h01}, 1'b0);
    cfg_write(1, 10'h000, 1'b0);
    cfg_write(2, 10'h000, 1'b0);
    cfg_write(3, 10'h003, 1'b1);
    out_ready = 1'b0;
    send(4'b0011, 2'd1);
    send(4'b0011, 2'd1);
    in_valid = 1'b0;
    cfg_write(0, {2'b10, 8'h04}, 1'b0);
    commit();
    checks++;
    if (cfg_pending !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL commit_wait: pending=%b in_ready=%b, required 1 0", cfg_pending, in_ready);
    end
    out_ready = 1'b1;
    send_expect(4'b0010, 2'd2, 2'b10, lat);
    checks++;
    if (cfg_pending !== 1'b0) begin
      failures++;
      $display("FAIL commit_done: pending=%b, required 0", cfg_pending);
    end
    cfg_write(3, 10'h000, 1'b1);
    send_expect(4'b0010, 2'd0, 2'b00, lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    cfg_write(0, {2'b01, 8'h00}, 1'b0);
    cfg_write(3, 10'h001, 1'b1);
    out_ready = 1'b0;
    send(4'($urandom), 2'($urandom));
    send(4'($urandom), 2'($urandom));
    in_valid = 1'b0;
    commit();
    rst_n = 1'b0;
    model_cfg_clear();
    tick();
    rst_n = 1'b1;
    checks++;
    if ({out_valid, out_vec, out_err, cfg_pending, in_ready} !== 6'b000001 ||
        err_cnt !== 16'd0 || max_err !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid: valid=%b vec=%b pend=%b ready=%b err_cnt=%0d max_err=%0d, required 0 00 0 1 0 0",
               out_valid, out_vec, cfg_pending, in_ready, err_cnt, max_err);
    end
    out_ready = 1'b1;
    send_expect(4'($urandom), 2'd0, 2'b00, lat);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clr_stats = 1'b0; cfg_addr = 2'd0; cfg_data = 10'd0; in_vec = 4'd0; in_exact = 2'd0;
    checks = 0; failures = 0; n_out = 0; mon_en = 1'b0; bp_en = 1'b0; bp_i = 0; bp_pat = 4'b1001;
    m_cnt = 0; m_cnt_s = 0; m_max = 0;
    model_cfg_clear();
    test_reset();
    test_const();
    test_literal();
    test_stats();
    test_back_to_back();
    test_commit();
    test_reset_mid();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
